// File: rtl/fma_pkg.sv
// ============================================================================
// fma_pkg : shared FMA datapath widths and alignment constants
// Rev 1.0
// ============================================================================
`default_nettype none

package fma_pkg;

  localparam int FMA_MAN_W   = 24;
  localparam int FMA_ALN_W   = 74;
  localparam int FMA_WIN_OFF = 50;
  localparam int FMA_SHF_MAX = 74;
  localparam int FMA_SHF_W   = 7;
  localparam int FMA_EXPT_W  = 10;
  localparam int FMA_EXPAB_W = 9;

  typedef struct packed {
    logic                   sub_eff;
    logic [FMA_EXPT_W-1:0]  exp_tmp;
    logic [FMA_EXPAB_W-1:0] exp_ab;
  } fma_pass_t;

  // Shifts past the window all land on the same answer, so saturate at the window edge.
  function automatic logic [FMA_SHF_W-1:0] clamp_shf(input logic [FMA_SHF_W-1:0] s);
    return (s > FMA_SHF_W'(FMA_SHF_MAX)) ? FMA_SHF_W'(FMA_SHF_MAX) : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shr_sticky.sv
// ============================================================================
// shr_sticky : zero-fill right shifter by amt*STEP, flags any dropped one bit
// Rev 1.0
// ============================================================================
`default_nettype none

module shr_sticky #(
  parameter int W     = 74,
  parameter int STEP  = 1,
  parameter int AMT_W = 4
) (
  input  logic [W-1:0]     din_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [W-1:0]     dout_o,
  output logic             drop_o
);

  localparam int SH_W = $clog2((2 ** AMT_W) * STEP) + 1;

  logic [SH_W-1:0] sh;

  assign sh = SH_W'(amt_i) * SH_W'(STEP);

  always_comb begin
    dout_o = din_i >> sh;
    drop_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(sh)) drop_o = drop_o | din_i[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/align_shifter.sv
// ============================================================================
// align_shifter : two-stage addend alignment (coarse 16-step, fine 1-step)
// Rev 1.0
// ============================================================================
`default_nettype none

module align_shifter
  import fma_pkg::*;
#(
  parameter int MAN_W = FMA_MAN_W,
  parameter int ALN_W = FMA_ALN_W,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W-1:0]       man_c,
  input  logic                   sub_eff,
  input  logic [FMA_SHF_W-1:0]   shf_num,
  input  logic [FMA_EXPT_W-1:0]  exp_tmp,
  input  logic [FMA_EXPAB_W-1:0] exp_ab,
  input  logic [TAG_W-1:0]       tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALN_W-1:0]       aligned_c,
  output logic                   sticky,
  output logic                   sub_eff_o,
  output logic [FMA_EXPT_W-1:0]  exp_tmp_o,
  output logic [FMA_EXPAB_W-1:0] exp_ab_o,
  output logic [TAG_W-1:0]       tag_out
);

  logic                 s1_adv, s2_adv;
  logic [FMA_SHF_W-1:0] shf_c;
  logic [ALN_W-1:0]     win0;

  logic                 s1_valid_q, s2_valid_q;
  logic [ALN_W-1:0]     win1_d, win1_q;
  logic                 sticky1_d, sticky1_q;
  logic [3:0]           fine_q;
  fma_pass_t            pass1_q, pass2_q;
  logic [TAG_W-1:0]     tag1_q, tag2_q;

  logic [ALN_W-1:0]     win2;
  logic                 drop2;
  logic [ALN_W-1:0]     aligned_q;
  logic                 sticky_q;

  // No skid buffer: backpressure ripples combinationally from out_ready to in_ready.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign shf_c = clamp_shf(shf_num);
  assign win0  = {man_c, {(ALN_W - MAN_W){1'b0}}};

  shr_sticky #(.W(ALN_W), .STEP(16), .AMT_W(3)) u_coarse (
    .din_i  (win0),
    .amt_i  (shf_c[6:4]),
    .dout_o (win1_d),
    .drop_o (sticky1_d)
  );

  shr_sticky #(.W(ALN_W), .STEP(1), .AMT_W(4)) u_fine (
    .din_i  (win1_q),
    .amt_i  (fine_q),
    .dout_o (win2),
    .drop_o (drop2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      win1_q     <= '0;
      sticky1_q  <= 1'b0;
      fine_q     <= '0;
      pass1_q    <= '0;
      tag1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        win1_q    <= win1_d;
        sticky1_q <= sticky1_d;
        fine_q    <= shf_c[3:0];
        pass1_q   <= '{sub_eff: sub_eff, exp_tmp: exp_tmp, exp_ab: exp_ab};
        tag1_q    <= tag_in;
      end
    end
  end

  // Sticky is a magnitude property of the dropped bits, so it is never complemented.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      aligned_q  <= '0;
      sticky_q   <= 1'b0;
      pass2_q    <= '0;
      tag2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        aligned_q <= pass1_q.sub_eff ? ~win2 : win2;
        sticky_q  <= sticky1_q | drop2;
        pass2_q   <= pass1_q;
        tag2_q    <= tag1_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign aligned_c = aligned_q;
  assign sticky    = sticky_q;
  assign sub_eff_o = pass2_q.sub_eff;
  assign exp_tmp_o = pass2_q.exp_tmp;
  assign exp_ab_o  = pass2_q.exp_ab;
  assign tag_out   = tag2_q;

endmodule

`default_nettype wire

// File: tb/tb_align_shifter.sv
// ============================================================================
// tb_align_shifter : directed and randomized scoreboard bench for align_shifter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_align_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [23:0] man_c;
  logic        sub_eff, sticky, sub_eff_o;
  logic [6:0]  shf_num;
  logic [9:0]  exp_tmp, exp_tmp_o;
  logic [8:0]  exp_ab, exp_ab_o;
  logic [3:0]  tag_in, tag_out;
  logic [73:0] aligned_c;

  typedef struct packed {
    logic [73:0] al;
    logic        st;
    logic        sub;
    logic [9:0]  et;
    logic [8:0]  eab;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic sb_en = 1'b0;
  logic acc;

  align_shifter #(.MAN_W(24), .ALN_W(74), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .man_c(man_c), .sub_eff(sub_eff), .shf_num(shf_num), .exp_tmp(exp_tmp),
    .exp_ab(exp_ab), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .aligned_c(aligned_c), .sticky(sticky), .sub_eff_o(sub_eff_o),
    .exp_tmp_o(exp_tmp_o), .exp_ab_o(exp_ab_o), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, expv);
    end
  endtask

  // Reference: place C at the top of a double-width field, shift, split into kept/dropped halves.
  function automatic exp_t model(input logic [23:0] man, input logic sub, input logic [6:0] shf,
                                 input logic [9:0] et, input logic [8:0] eab, input logic [3:0] tg);
    exp_t         e;
    logic [147:0] ext;
    int           s;
    s      = (int'(shf) > 74) ? 74 : int'(shf);
    ext    = {man, 124'b0} >> s;
    e.al   = sub ? ~ext[147:74] : ext[147:74];
    e.st   = |ext[73:0];
    e.sub  = sub;
    e.et   = et;
    e.eab  = eab;
    e.tag  = tg;
    return e;
  endfunction

  task automatic new_item();
    man_c   = ($urandom_range(0, 3) == 0) ? 24'($urandom) : (24'($urandom) | 24'h800000);
    shf_num = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 80));
    sub_eff = 1'($urandom);
    exp_tmp = 10'($urandom);
    exp_ab  = 9'($urandom);
    tag_in  = 4'($urandom);
  endtask

  task automatic tick();
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (!rst && sb_en) begin
      if (acc) q.push_back(model(man_c, sub_eff, shf_num, exp_tmp, exp_ab, tag_in));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious", {127'b0, out_valid}, 128'd0);
        end else begin
          e = q.pop_front();
          check("aligned", {54'b0, aligned_c}, {54'b0, e.al});
          check("sticky", {127'b0, sticky}, {127'b0, e.st});
          check("tag", {124'b0, tag_out}, {124'b0, e.tag});
          check("pass", {108'b0, sub_eff_o, exp_tmp_o, exp_ab_o}, {108'b0, e.sub, e.et, e.eab});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic directed(input string nm, input logic [23:0] man, input logic sub,
                          input logic [6:0] shf, input logic [73:0] eal, input logic est);
    in_valid = 1'b1; out_ready = 1'b1;
    man_c = man; sub_eff = sub; shf_num = shf;
    tag_in = 4'hA; exp_tmp = 10'h155; exp_ab = 9'h0AA;
    #1 check({nm, "_rdy"}, {127'b0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({nm, "_lat1"}, {127'b0, out_valid}, 128'd0);
    @(negedge clk);
    #1;
    check({nm, "_lat2"}, {127'b0, out_valid}, 128'd1);
    check({nm, "_al"}, {54'b0, aligned_c}, {54'b0, eal});
    check({nm, "_st"}, {127'b0, sticky}, {127'b0, est});
    check({nm, "_pass"}, {104'b0, tag_out, sub_eff_o, exp_tmp_o, exp_ab_o},
          {104'b0, 4'hA, sub, 10'h155, 9'h0AA});
    @(negedge clk);
  endtask

  initial begin
    logic [73:0] e1;
    logic [73:0] e5;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    man_c = '0; sub_eff = 1'b0; shf_num = '0; exp_tmp = '0; exp_ab = '0; tag_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ov", {127'b0, out_valid}, 128'd0);
    check("rst_al", {54'b0, aligned_c}, 128'd0);
    check("rst_st", {127'b0, sticky}, 128'd0);
    check("rst_ir", {127'b0, in_ready}, 128'd1);
    @(negedge clk);

    e1 = 74'd1 << 73;
    e5 = ~(74'h0ABCDEF);
    directed("d_top", 24'h800000, 1'b0, 7'd0, e1, 1'b0);
    directed("d_s60", 24'hFFFFFF, 1'b0, 7'd60, 74'h3FFF, 1'b1);
    directed("d_s74", 24'h800001, 1'b1, 7'd74, '1, 1'b1);
    directed("d_s100", 24'h800001, 1'b1, 7'd100, '1, 1'b1);
    directed("d_s50sub", 24'hABCDEF, 1'b1, 7'd50, e5, 1'b0);

    // Back-to-back stream, tags 0..7 in order.
    sb_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      new_item();
      in_valid = (k < 8); tag_in = 4'(k); out_ready = 1'b1;
      #1 check("stream_ov", {127'b0, out_valid}, {127'b0, (k >= 2 && k < 10)});
      tick();
    end

    // Stall with the pipeline full.
    new_item();
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      if (k >= 2) begin
        check("stall_ir", {127'b0, in_ready}, 128'd0);
        check("stall_ov", {127'b0, out_valid}, 128'd1);
        if (q.size() > 0) begin
          check("stall_al", {54'b0, aligned_c}, {54'b0, q[0].al});
          check("stall_tag", {124'b0, tag_out}, {124'b0, q[0].tag});
        end
      end
      tick();
      if (acc) new_item();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("drain", 128'(q.size()), 128'd0);

    // Reset with two items in flight.
    new_item();
    in_valid = 1'b1; out_ready = 1'b0;
    tick(); new_item(); tick();
    in_valid = 1'b0; rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_ov", {127'b0, out_valid}, 128'd0);
    check("mrst_al", {54'b0, aligned_c}, 128'd0);
    check("mrst_ir", {127'b0, in_ready}, 128'd1);
    out_ready = 1'b1;
    repeat (4) tick();

    // Random traffic with random backpressure.
    new_item();
    for (int k = 0; k < 500; k++) begin
      if (!in_valid) in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc) begin
        new_item();
        in_valid = ($urandom_range(0, 3) != 0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("final_drain", 128'(q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/align_shifter.md
Name: align_shifter

Overview:
- Pipelined addend-alignment stage of the FMA datapath.
- Sits directly downstream of the exponent handler: consumes shf_num, exp_tmp and exp_ab, plus the unpacked C mantissa.
- Right-shifts mantissa C into the 74-bit alignment window and collects the sticky bit. For effective subtraction it one's-complements the window.
- Feeds the 74-bit adder/LZA stage over a valid/ready handshake.

Parameters:
- MAN_W, 24, mantissa width including hidden bit.
- ALN_W, 74, alignment window width (MAN_W + 2 + 2*MAN_W).
- TAG_W, 4, opaque sideband tag carried alongside the data.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept this cycle.
- man_c  input  MAN_W  C mantissa with hidden bit.
- sub_eff  input  1  effective subtraction (sign_a^sign_b^sign_c).
- shf_num  input  7  right-shift amount from the exponent handler, legal range 0..74.
- exp_tmp  input  10  larger exponent, passed through.
- exp_ab  input  9  exp_a+exp_b, passed through.
- tag_in  input  TAG_W  sideband, passed through.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- aligned_c  output  ALN_W  aligned, optionally complemented C.
- sticky  output  1  OR of bits shifted out of the window.
- sub_eff_o, exp_tmp_o, exp_ab_o, tag_out  output  1/10/9/TAG_W  registered pass-through.

Behaviour:
- Latency: exactly 2 cycles from input accept to out_valid when never stalled. Throughput is 1 operation per cycle.
- Stage 1 (coarse) registers:
  - win1 = {man_c, 50'b0} >> (16*shf_c[6:4]), where shf_c = min(shf_num, 74).
  - Sticky1 = OR of bits dropped by the coarse shift.
  - Fine amount shf_c[3:0] and all pass-through fields.
- Stage 2 (fine) registers:
  - win2 = win1 >> shf_c[3:0].
  - sticky = sticky1 | OR of bits dropped by the fine shift.
  - aligned_c = sub_eff ? ~win2 : win2.
- Sticky is never complemented. Shift fill is zero before any complement.
- shf_num > 74 is clamped to 74: aligned_c = 0 (or all-ones if sub_eff), sticky = |man_c.
- shf_num <= 50: sticky = 0 by construction.
- Handshake:
  - A transfer occurs on valid&ready. Data and pass-through fields are held stable while out_valid && !out_ready.
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = s1 advances. It is combinational from out_ready; there is no skid buffer.
  - Full pipeline with out_ready=1: accept, shift and emit all in the same cycle, with no bubble.
  - Stall: out_ready=0 with both stages full drops in_ready to 0. No data is lost or duplicated.
- in_valid with in_ready=0 is ignored. Upstream holds its data.
- Reset:
  - s1_valid = s2_valid = 0, out_valid = 0.
  - All data/pass-through registers = 0, so aligned_c = 0 and sticky = 0.
  - Reset mid-operation discards in-flight items. in_ready = 1 in the first cycle after reset deasserts.

Decomposition:
- Shared fma_pkg holds: MAN_W, ALN_W, the window offset constant 50, the clamp constant 74, and the exponent widths (10, 9).
- One natural sub-module: shr_sticky, a combinational right shifter returning the shifted vector plus an OR-of-dropped-bits flag. It is parameterised on width and shift granularity and instantiated once per stage (coarse 16-step, fine 1-step).

Test Plan:
- man_c=0x800000, shf_num=0, sub_eff=0 -> 2 cycles later aligned_c = 0x800000<<50 (bit 73 set), sticky=0.
- man_c=0xFFFFFF, shf_num=60, sub_eff=0 -> aligned_c = 0x3FFF (bits 13..0), sticky=1.
- man_c=0x800001, shf_num=74, sub_eff=1 -> aligned_c = all ones (74 bits), sticky=1. Repeat with shf_num=100: identical result (clamp).
- Back-to-back 8 items, out_ready=1 -> out_valid continuous from cycle 2. Items emerge in order with matching tag_out 0..7.
- out_ready=0 for 5 cycles with pipeline full -> in_ready=0 and outputs held stable. On release, items drain in order with none lost or duplicated.
- Assert rst for 1 cycle with 2 items in flight -> out_valid=0 and aligned_c=0 the next cycle. in_ready=1 after release, and prior items never appear.
